// File: rtl/adder_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl_if
//   Request/response bundle between two operand producers, one result consumer
//   and the adder_seq_ctrl block.
//
//   Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both high. Once the sender raises valid it holds
//   its payload until that edge. A requester that drops valid before it is
//   granted is simply not served. The consumer may hold rsp_ready low for as
//   long as it likes.
//
//   Signals
//     req_valid [1:0]        per-requester request valid (bit i = requester i)
//     req_ready [1:0]        per-requester accept, at most one bit high
//     req_a     [2*WIDTH-1:0] operand A, requester i at [i*WIDTH +: WIDTH]
//     req_b     [2*WIDTH-1:0] operand B, same packing
//     req_cin   [1:0]        carry-in per requester
//     rsp_valid              result valid
//     rsp_ready              consumer accepts the result
//     rsp_id                 requester that owns the result
//     rsp_sum   [WIDTH-1:0]  A+B+Cin, low WIDTH bits
//     rsp_cout               carry out of bit WIDTH-1
//     rsp_ovf                signed overflow
//     busy                   job in flight or result waiting
//     dbg_state [1:0]        controller state (0 idle, 1 run, 2 done)
// -----------------------------------------------------------------------------
interface adder_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic [1:0]         req_cin;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [WIDTH-1:0]   rsp_sum;
   logic               rsp_cout;
   logic               rsp_ovf;
   logic               busy;
   logic [1:0]         dbg_state;

   // Controller side.
   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
             busy, dbg_state
   );

   // Producer/consumer side.
   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
             busy, dbg_state
   );
endinterface

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
//   Shares a single 4-bit full-adder slice between two requesters and runs it
//   nibble-serially to add WIDTH-bit operands with carry chaining. Round-robin
//   arbitration picks the next job. The result comes back on one response
//   channel tagged with the requester id.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    adder_seq_ctrl_if.slave: request/response channels, busy, state
//
//   Timing: the accepting edge moves to RUN. RUN lasts WIDTH/4 cycles, one
//   nibble per cycle, LSB first. rsp_valid rises WIDTH/4 edges after the
//   accepting edge and stays up until rsp_ready. Result registers hold their
//   last value while idle.
// -----------------------------------------------------------------------------
module adder_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   adder_seq_ctrl_if.slave bus
);
   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             last_grant_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;
   logic             id_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rsp_sum_q;
   logic             rsp_cout_q, rsp_ovf_q, rsp_id_q;

   logic             any_valid;
   logic             grant;
   logic             accept;
   logic             last_slice;
   logic [3:0]       s_nib;
   logic             slice_co;
   logic             slice_ovf;
   logic [WIDTH-1:0] acc_next;

   // Arbitration. A tie goes to the requester that was not served last.
   always_comb begin
      any_valid = |bus.req_valid;
      grant     = 1'b0;
      if (&bus.req_valid) grant = ~last_grant_q;
      else                grant = bus.req_valid[1];
      accept = (state_q == S_IDLE) && any_valid;
      bus.req_ready = 2'b00;
      if (accept) bus.req_ready[grant] = 1'b1;
   end

   // Shared 4-bit slice. carry_q is loaded with cin on accept, so slice 0
   // sees the requester's carry-in.
   always_comb begin
      {slice_co, s_nib} = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + 5'(carry_q);
      // On the final slice the low nibbles are the operand sign nibbles.
      slice_ovf  = (a_q[3] == b_q[3]) && (s_nib[3] != a_q[3]);
      last_slice = (cnt_q == LAST_SLICE);
   end

   // Partial sums collect in a shift register that is one nibble shorter than
   // WIDTH. The current slice's nibble completes it, so the full sum is ready
   // in the same cycle as the final slice.
   generate
      if (NSLICE > 1) begin : g_acc
         logic [WIDTH-5:0] acc_q;
         assign acc_next = {s_nib, acc_q};
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                acc_q <= '0;
            else if (state_q == S_RUN) acc_q <= acc_next[WIDTH-1:4];
         end
      end else begin : g_acc1
         assign acc_next = s_nib;
      end
   endgenerate

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)        state_d = S_RUN;
         S_RUN:   if (last_slice)    state_d = S_DONE;
         S_DONE:  if (bus.rsp_ready) state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         carry_q      <= 1'b0;
         id_q         <= 1'b0;
         cnt_q        <= '0;
         rsp_sum_q    <= '0;
         rsp_cout_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         rsp_id_q     <= 1'b0;
      end else begin
         if (accept) begin
            a_q          <= grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
            b_q          <= grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
            carry_q      <= bus.req_cin[grant];
            id_q         <= grant;
            last_grant_q <= grant;
            cnt_q        <= '0;
         end else if (state_q == S_RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            carry_q <= slice_co;
            cnt_q   <= cnt_q + CW'(1);
            if (last_slice) begin
               rsp_sum_q  <= acc_next;
               rsp_cout_q <= slice_co;
               rsp_ovf_q  <= slice_ovf;
               rsp_id_q   <= id_q;
            end
         end
      end
   end

   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;
   localparam int W  = 16;
   localparam int NS = W / 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adder_seq_ctrl_if #(.WIDTH(W)) bus ();
   adder_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [W+2:0] exp_q[$];   // {id, cout, ovf, sum}

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain wide addition and the two's-complement overflow rule.
   function automatic logic [W+2:0] model(input logic id, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
      logic [W:0] t;
      logic       ov;
      t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return {id, t[W], ov, t[W-1:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 with the DUT idle. Returns at posedge+1 after the
   // response handshake edge. With hold > 0 the consumer stalls in DONE while
   // the other requester asks for service.
   task automatic run_job(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int hold, output logic [W+2:0] got);
      int lat;
      int other;
      logic [W+2:0] first;
      logic stable;
      logic blocked;
      other = 1 - id;
      bus.req_a[id*W +: W] = a;
      bus.req_b[id*W +: W] = b;
      bus.req_cin[id]      = cin;
      bus.req_valid[id]    = 1'b1;
      exp_q.push_back(model(id[0], a, b, cin));
      @(negedge clk);
      check("req_ready_same_cycle", 64'(bus.req_ready), (id == 0) ? 64'h1 : 64'h2);
      @(posedge clk);
      #1;
      bus.req_valid[id]    = 1'b0;
      bus.req_a[id*W +: W] = W'($urandom);
      bus.req_b[id*W +: W] = W'($urandom);
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 64'(lat), 64'(NS));
      first = {bus.rsp_id, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum};
      if (hold > 0) begin
         stable  = 1'b1;
         blocked = 1'b1;
         bus.req_valid[other] = 1'b1;
         bus.rsp_ready        = 1'b0;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if ({bus.rsp_id, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum} !== first ||
                bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1) stable = 1'b0;
            if (bus.req_ready !== 2'b00) blocked = 1'b0;
         end
         check("done_stable", 64'(stable), 64'h1);
         check("done_no_accept", 64'(blocked), 64'h1);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      got = first;
      if (exp_q.size() > 0) check("sb_result", 64'(got), 64'(exp_q.pop_front()));
      else                  check("sb_nonempty", 64'h0, 64'h1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [W+2:0] got;
      logic [W-1:0] op_a[2];
      logic [W-1:0] op_b[2];
      logic         op_c[2];
      logic [W+2:0] e;
      int           wt;
      int           lat;
      int           eid;
      logic         loser_ok;

      vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

      bus.req_valid = 2'b00;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = 2'b00;
      bus.rsp_ready = 1'b0;
      rst_n         = 1'b0;
      @(negedge clk);
      check("reset_outputs",
            64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_ovf,
                 bus.busy, bus.rsp_sum}), 64'h0);
      do_reset();

      // Directed vectors.
      for (int i = 0; i < 6; i++) begin
         run_job(int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].cin, 0, got);
         check($sformatf("vec%0d_sum", i), 64'(got[W-1:0]), 64'(vecs[i].sum));
         check($sformatf("vec%0d_ovf", i), 64'(got[W]), 64'(vecs[i].ovf));
         check($sformatf("vec%0d_cout", i), 64'(got[W+1]), 64'(vecs[i].cout));
         check($sformatf("vec%0d_id", i), 64'(got[W+2]), 64'(vecs[i].id));
      end

      // Consumer stalls 10 cycles in DONE while requester 1 waits.
      bus.req_a[W +: W] = 16'h1111;
      bus.req_b[W +: W] = 16'h2222;
      bus.req_cin[1]    = 1'b0;
      run_job(0, 16'h0101, 16'h0202, 1'b0, 10, got);
      @(negedge clk);
      check("after_done_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      check("after_done_busy", 64'(bus.busy), 64'h0);
      check("after_done_ready", 64'(bus.req_ready), 64'h2);
      check("held_sum_idle", 64'(bus.rsp_sum), 64'h0303);
      bus.req_valid = 2'b00;
      @(posedge clk);
      #1;

      // Round robin: both requesters valid for four jobs.
      do_reset();
      bus.rsp_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         op_a[r] = W'($urandom);
         op_b[r] = W'($urandom);
         op_c[r] = 1'($urandom_range(0, 1));
         bus.req_a[r*W +: W] = op_a[r];
         bus.req_b[r*W +: W] = op_b[r];
         bus.req_cin[r]      = op_c[r];
      end
      bus.req_valid = 2'b11;
      for (int j = 0; j < 4; j++) begin
         eid = j % 2;
         wt  = 0;
         @(negedge clk);
         while (bus.req_ready == 2'b00 && wt < 20) begin
            @(negedge clk);
            wt++;
         end
         check($sformatf("rr_grant%0d", j), 64'(bus.req_ready), (eid == 0) ? 64'h1 : 64'h2);
         e = model(eid[0], op_a[eid], op_b[eid], op_c[eid]);
         @(posedge clk);
         #1;
         op_a[eid] = W'($urandom);
         op_b[eid] = W'($urandom);
         op_c[eid] = 1'($urandom_range(0, 1));
         bus.req_a[eid*W +: W] = op_a[eid];
         bus.req_b[eid*W +: W] = op_b[eid];
         bus.req_cin[eid]      = op_c[eid];
         loser_ok = 1'b1;
         lat = 0;
         while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.req_ready !== 2'b00) loser_ok = 1'b0;
         end
         check($sformatf("rr_loser_blocked%0d", j), 64'(loser_ok), 64'h1);
         check($sformatf("rr_result%0d", j),
               64'({bus.rsp_id, bus.rsp_cout, bus.rsp_ovf, bus.rsp_sum}), 64'(e));
      end
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b0;

      // Randomized jobs with random consumer stalls.
      for (int n = 0; n < 30; n++) begin
         int id;
         int hold;
         id   = $urandom_range(0, 1);
         hold = $urandom_range(0, 3);
         bus.req_a[(1-id)*W +: W] = W'($urandom);
         bus.req_b[(1-id)*W +: W] = W'($urandom);
         run_job(id, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), hold, got);
         bus.req_valid = 2'b00;
      end

      // Reset during slice 2 aborts the job.
      bus.req_a[W-1:0] = 16'hABCD;
      bus.req_b[W-1:0] = 16'h1111;
      bus.req_cin[0]   = 1'b0;
      bus.req_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("busy_before_abort", 64'(bus.busy), 64'h1);
      rst_n = 1'b0;
      #1;
      check("abort_outputs_zero",
            64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_ovf,
                 bus.busy, bus.rsp_sum}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.req_a[W +: W] = 16'h5555;
      bus.req_b[W +: W] = 16'h0001;
      bus.req_cin[1]    = 1'b0;
      bus.req_valid[1]  = 1'b1;
      run_job(0, 16'h4321, 16'h1234, 1'b1, 0, got);
      bus.req_valid = 2'b00;
      check("post_abort_sum", 64'(got[W-1:0]), 64'h5556);
      check("post_abort_id", 64'(got[W+2]), 64'h0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end
endmodule
